// File: rtl/spif_pkt_pkg.sv
// Shared definitions for SpiNNaker multicast packet assembly: header bit positions,
// packet field offsets, assembler states and the odd-parity check.
package spif_pkt_pkg;

  localparam int unsigned HDR_PLD_BIT = 1;
  localparam int unsigned HDR_PTY_BIT = 0;

  localparam int unsigned HDR_LSB = 0;
  localparam int unsigned KEY_LSB = 8;
  localparam int unsigned PLD_LSB = 40;

  typedef enum logic [1:0] {
    HDR = 2'd0,
    KEY = 2'd1,
    PLD = 2'd2
  } asm_state_t;

  // Packets carry odd parity over every transmitted bit, payload only when present.
  function automatic logic pkt_parity_ok(input logic [7:0]  hdr,
                                         input logic [31:0] key,
                                         input logic [31:0] pld,
                                         input logic        pst);
    logic p;
    p = ^{hdr, key};
    if (pst) p = p ^ (^pld);
    return p;
  endfunction

endpackage

// File: rtl/pkt_out_reg.sv
// Single-entry registered valid/ready output stage; a new packet may be loaded in the
// same cycle the current one is taken, giving full-rate back-to-back delivery.
module pkt_out_reg #(
  parameter int unsigned DATA_BITS = 72
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_load,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_rdy,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_vld,
  output logic                 o_space
);

  logic [DATA_BITS-1:0] r_data;
  logic                 r_vld;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data <= '0;
      r_vld  <= 1'b0;
    end else if (i_load) begin
      r_data <= i_data;
      r_vld  <= 1'b1;
    end else if (r_vld && i_rdy) begin
      r_vld  <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_vld   = r_vld;
  assign o_space = !r_vld || i_rdy;

endmodule

// File: rtl/pkt_assembler.sv
// Assembles header/key/payload words into 72-bit multicast packets, drops packets with
// bad parity and keeps a saturating count of them.
module pkt_assembler
  import spif_pkt_pkg::*;
#(
  parameter int unsigned PACKET_BITS = 72,
  parameter int unsigned WORD_BITS   = 32,
  parameter int unsigned CTR_BITS    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_BITS-1:0]   wrd_data_in,
  input  logic                   wrd_vld_in,
  output logic                   wrd_rdy_out,
  output logic [PACKET_BITS-1:0] pkt_data_out,
  output logic                   pkt_vld_out,
  input  logic                   pkt_rdy_in,
  output logic                   perr_out,
  output logic [CTR_BITS-1:0]    perr_ctr_out,
  input  logic                   clr_ctr_in
);

  asm_state_t             r_state;
  logic [7:0]             r_hdr;
  logic [WORD_BITS-1:0]   r_key;
  logic                   r_perr;
  logic [CTR_BITS-1:0]    r_perr_ctr;

  logic                   w_pst;
  logic                   w_final;
  logic                   w_space;
  logic                   w_rdy;
  logic                   w_acc;
  logic                   w_ok;
  logic                   w_load;
  logic                   w_bad;
  logic [PACKET_BITS-1:0] w_pkt;

  assign w_pst   = r_hdr[HDR_PLD_BIT];
  assign w_final = ((r_state == KEY) && !w_pst) || (r_state == PLD);

  // Ready depends only on state and output-stage space, never on wrd_vld_in.
  assign w_rdy = (r_state == HDR) || ((r_state == KEY) && w_pst) || (w_final && w_space);
  assign w_acc = wrd_vld_in && w_rdy;

  always_comb begin
    w_pkt = '0;
    w_ok  = 1'b0;
    w_pkt[HDR_LSB +: 8] = r_hdr;
    if (r_state == KEY) begin
      w_pkt[KEY_LSB +: WORD_BITS] = wrd_data_in;
      w_ok = pkt_parity_ok(r_hdr, wrd_data_in, '0, 1'b0);
    end else begin
      w_pkt[KEY_LSB +: WORD_BITS] = r_key;
      w_pkt[PLD_LSB +: WORD_BITS] = wrd_data_in;
      w_ok = pkt_parity_ok(r_hdr, r_key, wrd_data_in, 1'b1);
    end
  end

  assign w_load = w_acc && w_final && w_ok;
  assign w_bad  = w_acc && w_final && !w_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= HDR;
      r_hdr   <= '0;
      r_key   <= '0;
    end else if (w_acc) begin
      case (r_state)
        HDR: begin
          r_hdr   <= wrd_data_in[7:0];
          r_state <= KEY;
        end
        KEY: begin
          r_key   <= wrd_data_in;
          r_state <= w_pst ? PLD : HDR;
        end
        PLD:     r_state <= HDR;
        default: r_state <= HDR;
      endcase
    end
  end

  // Clear wins over a simultaneous error; the pulse is still raised.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perr     <= 1'b0;
      r_perr_ctr <= '0;
    end else begin
      r_perr <= w_bad;
      if (clr_ctr_in) begin
        r_perr_ctr <= '0;
      end else if (w_bad && (r_perr_ctr != '1)) begin
        r_perr_ctr <= r_perr_ctr + 1'b1;
      end
    end
  end

  pkt_out_reg #(
    .DATA_BITS (PACKET_BITS)
  ) u_out (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_data  (w_pkt),
    .i_rdy   (pkt_rdy_in),
    .o_data  (pkt_data_out),
    .o_vld   (pkt_vld_out),
    .o_space (w_space)
  );

  assign wrd_rdy_out  = w_rdy && reset;
  assign perr_out     = r_perr;
  assign perr_ctr_out = r_perr_ctr;

endmodule

// File: tb/tb_pkt_assembler.sv
// Directed-vector bench for pkt_assembler with a queue-based scoreboard and a separate
// output monitor; a narrow error counter keeps the saturation case short.
module tb_pkt_assembler;

  localparam int unsigned CB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   wrd_data_in = '0;
  logic          wrd_vld_in = 1'b0;
  logic          wrd_rdy_out;
  logic [71:0]   pkt_data_out;
  logic          pkt_vld_out;
  logic          pkt_rdy_in = 1'b1;
  logic          perr_out;
  logic [CB-1:0] perr_ctr_out;
  logic          clr_ctr_in = 1'b0;

  int unsigned   errors = 0;
  int unsigned   checks = 0;
  logic [71:0]   exp_q[$];
  int unsigned   exp_perr = 0;
  logic [CB-1:0] ctr_exp = '0;
  bit            ok;

  pkt_assembler #(
    .PACKET_BITS (72),
    .WORD_BITS   (32),
    .CTR_BITS    (CB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wrd_data_in  (wrd_data_in),
    .wrd_vld_in   (wrd_vld_in),
    .wrd_rdy_out  (wrd_rdy_out),
    .pkt_data_out (pkt_data_out),
    .pkt_vld_out  (pkt_vld_out),
    .pkt_rdy_in   (pkt_rdy_in),
    .perr_out     (perr_out),
    .perr_ctr_out (perr_ctr_out),
    .clr_ctr_in   (clr_ctr_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit clr, output bit acc);
    @(negedge clk);
    wrd_data_in = w;
    wrd_vld_in  = 1'b1;
    clr_ctr_in  = clr;
    acc = 1'b0;
    for (int n = 0; n < 50; n++) begin
      #1;
      if (wrd_rdy_out) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (acc) begin
      @(posedge clk);
    end else begin
      errors++;
      $display("FAIL word_timeout: got rdy=0 for word %h expected rdy=1 within 50 cycles", w);
      wrd_vld_in = 1'b0;
    end
  endtask

  task automatic send_final(input logic [31:0] w, input bit good, input logic [71:0] exp,
                            input bit clr);
    bit acc;
    send_word(w, clr, acc);
    if (acc) begin
      if (good) exp_q.push_back(exp);
      else exp_perr++;
      if (clr) ctr_exp = '0;
      else if (!good && ctr_exp != '1) ctr_exp = ctr_exp + 1'b1;
    end
  endtask

  task automatic send_pkt(input logic [31:0] hw, input logic [31:0] kw, input logic [31:0] pw,
                          input bit good, input logic [71:0] exp, input bit clr);
    bit acc;
    send_word(hw, 1'b0, acc);
    if (hw[1]) begin
      send_word(kw, 1'b0, acc);
      send_final(pw, good, exp, clr);
    end else begin
      send_final(kw, good, exp, clr);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    wrd_vld_in = 1'b0;
    clr_ctr_in = 1'b0;
    #2;
  endtask

  // Monitor: every valid output cycle must show the oldest expected packet.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        if (pkt_vld_out) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pkt", pkt_data_out, 72'hx);
          end else begin
            check("pkt_data", pkt_data_out, exp_q[0]);
            if (pkt_rdy_in) void'(exp_q.pop_front());
          end
        end
        if (perr_out) begin
          checks++;
          if (exp_perr == 0) begin
            errors++;
            $display("FAIL perr_pulse: got perr_out=1 expected 0 (no bad packet pending)");
          end else begin
            exp_perr--;
          end
        end
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    #2;
    check("rst_vld", {71'd0, pkt_vld_out}, 72'd0);
    check("rst_data", pkt_data_out, 72'd0);
    check("rst_perr", {71'd0, perr_out}, 72'd0);
    check("rst_ctr", {{(72-CB){1'b0}}, perr_ctr_out}, 72'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rdy_after_rst", {71'd0, wrd_rdy_out}, 72'd1);

    // 1: no payload, one-cycle latency
    send_pkt(32'h01, 32'h0, 32'h0, 1'b1, 72'h00_0000_0000_0000_0001, 1'b0);
    idle();
    check("t1_lat_vld", {71'd0, pkt_vld_out}, 72'd1);

    // 2: payload
    send_pkt(32'h03, 32'h1, 32'h0, 1'b1, 72'h00_0000_0000_0000_0103, 1'b0);
    idle();
    check("t2_ctr", {{(72-CB){1'b0}}, perr_ctr_out}, {{(72-CB){1'b0}}, ctr_exp});

    // 3: bad parity, then a good packet still delivered
    send_pkt(32'h00, 32'h0, 32'h0, 1'b0, 72'h0, 1'b0);
    idle();
    check("t3_ctr", {{(72-CB){1'b0}}, perr_ctr_out}, 72'd1);
    send_pkt(32'h01, 32'h0, 32'h0, 1'b1, 72'h00_0000_0000_0000_0001, 1'b0);

    // Extra patterns, back-to-back, upper header bits ignored
    send_pkt(32'h02, 32'h1, 32'h8000_0000, 1'b1, 72'h80_0000_0000_0000_0102, 1'b0);
    send_pkt(32'hABCD_00F5, 32'hDEAD_BEEE, 32'h0, 1'b1, 72'h00_0000_00DE_ADBE_EEF5, 1'b0);
    send_pkt(32'hFFFF_FF06, 32'h3, 32'h1, 1'b1, 72'h00_0000_0100_0000_0306, 1'b0);
    send_pkt(32'h02, 32'h0, 32'h1, 1'b0, 72'h0, 1'b0);
    idle();
    check("ctr_after_bad_pld", {{(72-CB){1'b0}}, perr_ctr_out}, 72'd2);

    // 4: backpressure with one pending and one streaming
    pkt_rdy_in = 1'b0;
    send_pkt(32'h01, 32'h0, 32'h0, 1'b1, 72'h00_0000_0000_0000_0001, 1'b0);
    send_word(32'h03, 1'b0, ok);
    send_word(32'h01, 1'b0, ok);
    fork
      send_final(32'h0, 1'b1, 72'h00_0000_0000_0000_0103, 1'b0);
      begin
        repeat (3) @(negedge clk);
        #1;
        check("t4_rdy_stall", {71'd0, wrd_rdy_out}, 72'd0);
        @(negedge clk);
        pkt_rdy_in = 1'b1;
      end
    join
    idle();
    idle();
    check("t4_drained", {71'd0, pkt_vld_out}, 72'd0);

    // 5: saturation then clear with a simultaneous error
    for (int i = 0; i < 20 && ctr_exp != '1; i++)
      send_pkt(32'h00, 32'h0, 32'h0, 1'b0, 72'h0, 1'b0);
    idle();
    check("t5_full", {{(72-CB){1'b0}}, perr_ctr_out}, {{(72-CB){1'b0}}, {CB{1'b1}}});
    send_pkt(32'h00, 32'h0, 32'h0, 1'b0, 72'h0, 1'b0);
    idle();
    check("t5_sat", {{(72-CB){1'b0}}, perr_ctr_out}, {{(72-CB){1'b0}}, {CB{1'b1}}});
    send_pkt(32'h00, 32'h0, 32'h0, 1'b0, 72'h0, 1'b1);
    idle();
    check("t5_clr_ctr", {{(72-CB){1'b0}}, perr_ctr_out}, 72'd0);
    check("t5_clr_perr", {71'd0, perr_out}, 72'd1);

    // 6: reset mid-packet with a pending packet
    send_pkt(32'h00, 32'h0, 32'h0, 1'b0, 72'h0, 1'b0);
    idle();
    idle();
    pkt_rdy_in = 1'b0;
    send_pkt(32'h01, 32'h0, 32'h0, 1'b1, 72'h00_0000_0000_0000_0001, 1'b0);
    send_word(32'h03, 1'b0, ok);
    send_word(32'h01, 1'b0, ok);
    @(negedge clk);
    wrd_vld_in = 1'b0;
    reset = 1'b0;
    exp_q.delete();
    ctr_exp = '0;
    #2;
    check("t6_vld", {71'd0, pkt_vld_out}, 72'd0);
    check("t6_data", pkt_data_out, 72'd0);
    check("t6_perr", {71'd0, perr_out}, 72'd0);
    check("t6_ctr", {{(72-CB){1'b0}}, perr_ctr_out}, 72'd0);
    check("t6_rdy", {71'd0, wrd_rdy_out}, 72'd0);
    @(negedge clk);
    reset = 1'b1;
    pkt_rdy_in = 1'b1;
    send_pkt(32'h01, 32'h0, 32'h0, 1'b1, 72'h00_0000_0000_0000_0001, 1'b0);
    idle();
    check("t6_after_vld", {71'd0, pkt_vld_out}, 72'd1);
    repeat (3) idle();

    check("sb_empty", 72'(exp_q.size()), 72'd0);
    check("perr_all_seen", 72'(exp_perr), 72'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
